// File: rtl/hamming_pkg.sv
// ============================================================================
// Module      : hamming_pkg
// Description : Shared types and constants for the Hamming(7,4) receive path.
//               Holds the deserialiser FSM state encoding, the code-word
//               widths and the serial framing levels.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package hamming_pkg;

    // Receive framing FSM
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_STOP = 2'd2
    } rx_state_t;

    localparam int   CW_W      = 8;     // code word incl. unused bit 0
    localparam int   CODE_BITS = 7;     // Hamming(7,4) positions 1..7
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/hamming_rx_deser_if.sv
// ============================================================================
// Module      : hamming_rx_deser_if
// Description : Serial-in / code-word-out bundle of the Hamming receive
//               deserialiser.
//               rx_bit/rx_valid   : serial bit and one-cycle strobe
//               cw_data/cw_valid  : 8-bit code word slot, cw_ready accepts
//               frame_err/overrun : one-cycle status pulses
//               Modport slave is the deserialiser, master is its environment.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface hamming_rx_deser_if;
    import hamming_pkg::*;

    logic            rx_bit;
    logic            rx_valid;
    logic [CW_W-1:0] cw_data;
    logic            cw_valid;
    logic            cw_ready;
    logic            frame_err;
    logic            overrun;

    modport slave (
        input  rx_bit, rx_valid, cw_ready,
        output cw_data, cw_valid, frame_err, overrun
    );

    modport master (
        output rx_bit, rx_valid, cw_ready,
        input  cw_data, cw_valid, frame_err, overrun
    );

endinterface

`default_nettype wire

// File: rtl/hamming_sat_cnt.sv
// ============================================================================
// Module      : hamming_sat_cnt
// Description : Saturating up-counter, asynchronous active-low reset.
//               i_inc : count enable (one step per cycle)
//               o_cnt : current count, sticks at all-ones
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module hamming_sat_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/hamming_rx_deser.sv
// ============================================================================
// Module      : hamming_rx_deser
// Description : Frames a start/stop delimited serial stream into Hamming(7,4)
//               code words (positions 1..7, bit 0 = 0) and offers each word
//               in a one-entry valid/ready slot. Bad stop bits and inter-bit
//               timeouts pulse frame_err; a good frame arriving at a full,
//               non-draining slot pulses overrun and is discarded.
// Ports       : clk, rst_n (async, active low)
//               bus  : hamming_rx_deser_if.slave
//               o_frame_err_cnt / o_overrun_cnt (only with HAMMING_RX_ERRCNT_EN)
// Parameters  : TIMEOUT - max clocks between strobes inside a frame, 0 = off
// Options     : `define HAMMING_RX_ERRCNT_EN adds saturating error counters
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module hamming_rx_deser
    import hamming_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    hamming_rx_deser_if.slave      bus
`ifdef HAMMING_RX_ERRCNT_EN
    ,
    output logic [7:0]             o_frame_err_cnt,
    output logic [7:0]             o_overrun_cnt
`endif
);

    // Gap counter only needs to represent 0..TIMEOUT-1: reaching the last
    // value with no strobe on that cycle is the timeout.
    localparam int            GW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [GW-1:0] c_GAP_LAST = (TIMEOUT > 0) ? GW'(TIMEOUT - 1) : '0;

    rx_state_t          r_state;
    logic [2:0]         r_bit_cnt;
    logic [CODE_BITS:1] r_shreg;
    logic [GW-1:0]      r_gap;
    logic [CW_W-1:0]    r_cw_data;
    logic               r_cw_valid;
    logic               r_frame_err;
    logic               r_overrun;

    logic               w_timeout;
    logic               w_slot_free;

    assign w_timeout   = (TIMEOUT > 0) && (r_state != S_IDLE) &&
                         !bus.rx_valid && (r_gap == c_GAP_LAST);
    // Slot may be loaded when empty or when the held word leaves this cycle
    assign w_slot_free = !r_cw_valid || bus.cw_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_gap       <= '0;
            r_cw_data   <= '0;
            r_cw_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;

            // Accept drains the slot; a load below overrides this
            if (r_cw_valid && bus.cw_ready) begin
                r_cw_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_gap <= '0;
                    if (bus.rx_valid && (bus.rx_bit == START_LVL)) begin
                        r_state   <= S_DATA;
                        r_bit_cnt <= '0;
                    end
                end

                S_DATA: begin
                    if (bus.rx_valid) begin
                        r_gap                      <= '0;
                        r_shreg[r_bit_cnt + 3'd1]  <= bus.rx_bit;
                        r_bit_cnt                  <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd6) begin
                            r_state <= S_STOP;
                        end
                    end else if (w_timeout) begin
                        r_frame_err <= 1'b1;
                        r_state     <= S_IDLE;
                        r_bit_cnt   <= '0;
                        r_gap       <= '0;
                    end else begin
                        r_gap <= r_gap + GW'(1);
                    end
                end

                S_STOP: begin
                    if (bus.rx_valid) begin
                        r_gap     <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= S_IDLE;
                        // A low stop bit is not treated as the next start bit
                        if (bus.rx_bit == STOP_LVL) begin
                            if (w_slot_free) begin
                                r_cw_data  <= {r_shreg, 1'b0};
                                r_cw_valid <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_frame_err <= 1'b1;
                        r_state     <= S_IDLE;
                        r_bit_cnt   <= '0;
                        r_gap       <= '0;
                    end else begin
                        r_gap <= r_gap + GW'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cw_data   = r_cw_data;
    assign bus.cw_valid  = r_cw_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = r_overrun;

`ifdef HAMMING_RX_ERRCNT_EN
    hamming_sat_cnt #(.WIDTH(8)) u_frame_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (r_frame_err),
        .o_cnt (o_frame_err_cnt)
    );

    hamming_sat_cnt #(.WIDTH(8)) u_overrun_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (r_overrun),
        .o_cnt (o_overrun_cnt)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_hamming_rx_deser.sv
// ============================================================================
// Module      : tb_hamming_rx_deser
// Description : Directed self-checking bench for hamming_rx_deser with
//               TIMEOUT=4. Covers reset, good frame, backpressure/overrun,
//               bad stop bit, timeout, drain-and-load, reset mid-frame and,
//               with HAMMING_RX_ERRCNT_EN, counter saturation.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hamming_rx_deser;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;

    hamming_rx_deser_if u_if ();

`ifdef HAMMING_RX_ERRCNT_EN
    logic [7:0] w_frame_err_cnt;
    logic [7:0] w_overrun_cnt;
`endif

    hamming_rx_deser #(.TIMEOUT(4)) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (u_if.slave)
`ifdef HAMMING_RX_ERRCNT_EN
        ,
        .o_frame_err_cnt (w_frame_err_cnt),
        .o_overrun_cnt   (w_overrun_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One strobe; returns 1 time unit after the sampling edge
    task automatic send_bit(input logic b);
        u_if.rx_valid = 1'b1;
        u_if.rx_bit   = b;
        @(posedge clk);
        #1;
        u_if.rx_valid = 1'b0;
        u_if.rx_bit   = 1'b0;
    endtask

    task automatic send_code(input logic [7:0] cw);
        for (int i = 1; i <= 7; i++) send_bit(cw[i]);
    endtask

    task automatic send_frame(input logic [7:0] cw, input logic stop);
        send_bit(1'b0);
        send_code(cw);
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        u_if.rx_bit   = 1'b0;
        u_if.rx_valid = 1'b0;
        u_if.cw_ready = 1'b0;
        rst_n         = 1'b0;
        #2;
        check_eq("reset_cw_data",   u_if.cw_data,   8'h00);
        check_eq("reset_cw_valid",  u_if.cw_valid,  0);
        check_eq("reset_frame_err", u_if.frame_err, 0);
        check_eq("reset_overrun",   u_if.overrun,   0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Good frame
        send_frame(8'hCC, 1'b1);
        check_eq("good_cw_data",   u_if.cw_data,   8'hCC);
        check_eq("good_cw_valid",  u_if.cw_valid,  1);
        check_eq("good_frame_err", u_if.frame_err, 0);
        check_eq("good_overrun",   u_if.overrun,   0);
        u_if.cw_ready = 1'b1;
        idle(1);
        check_eq("good_drained", u_if.cw_valid, 0);
        u_if.cw_ready = 1'b0;
        idle(2);

        // Backpressure and overrun
        send_frame(8'hCC, 1'b1);
        check_eq("bp_first_valid", u_if.cw_valid, 1);
        send_frame(8'h1E, 1'b1);
        check_eq("bp_overrun_pulse", u_if.overrun, 1);
        check_eq("bp_data_kept",     u_if.cw_data, 8'hCC);
        idle(1);
        check_eq("bp_overrun_single", u_if.overrun, 0);
        check_eq("bp_data_still",     u_if.cw_data, 8'hCC);
        check_eq("bp_valid_held",     u_if.cw_valid, 1);
        u_if.cw_ready = 1'b1;
        idle(1);
        check_eq("bp_accept", u_if.cw_valid, 0);
        u_if.cw_ready = 1'b0;
        idle(2);

        // Bad stop bit, then a back-to-back good frame
        send_frame(8'hCC, 1'b0);
        check_eq("badstop_err",   u_if.frame_err, 1);
        check_eq("badstop_valid", u_if.cw_valid,  0);
        send_bit(1'b0);
        check_eq("badstop_err_single", u_if.frame_err, 0);
        send_code(8'h1E);
        send_bit(1'b1);
        check_eq("b2b_data",  u_if.cw_data,  8'h1E);
        check_eq("b2b_valid", u_if.cw_valid, 1);
        u_if.cw_ready = 1'b1;
        idle(1);
        u_if.cw_ready = 1'b0;
        idle(2);

        // Timeout: start + 3 data bits, then idle
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        idle(3);
        check_eq("to_not_yet", u_if.frame_err, 0);
        idle(1);
        check_eq("to_pulse", u_if.frame_err, 1);
        idle(1);
        check_eq("to_single", u_if.frame_err, 0);
        send_frame(8'hCC, 1'b1);
        check_eq("to_after_data",  u_if.cw_data,  8'hCC);
        check_eq("to_after_valid", u_if.cw_valid, 1);
        u_if.cw_ready = 1'b1;
        idle(1);
        u_if.cw_ready = 1'b0;
        idle(2);

        // Drain-and-load: accept coincides with the next stop strobe
        send_frame(8'hCC, 1'b1);
        send_bit(1'b0);
        send_code(8'h1E);
        u_if.cw_ready = 1'b1;
        send_bit(1'b1);
        check_eq("dl_overrun", u_if.overrun,  0);
        check_eq("dl_valid",   u_if.cw_valid, 1);
        check_eq("dl_data",    u_if.cw_data,  8'h1E);
        idle(1);
        check_eq("dl_drained", u_if.cw_valid, 0);
        u_if.cw_ready = 1'b0;
        idle(2);

        // Reset mid-frame with a word held
        send_frame(8'hCC, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_data",  u_if.cw_data,   8'h00);
        check_eq("rst_mid_valid", u_if.cw_valid,  0);
        check_eq("rst_mid_err",   u_if.frame_err, 0);
        check_eq("rst_mid_ovr",   u_if.overrun,   0);
`ifdef HAMMING_RX_ERRCNT_EN
        check_eq("rst_mid_errcnt", w_frame_err_cnt, 8'h00);
        check_eq("rst_mid_ovrcnt", w_overrun_cnt,   8'h00);
`endif
        idle(2);
        rst_n = 1'b1;
        idle(1);
        send_frame(8'hCC, 1'b1);
        check_eq("post_rst_data",  u_if.cw_data,  8'hCC);
        check_eq("post_rst_valid", u_if.cw_valid, 1);
        u_if.cw_ready = 1'b1;
        idle(1);
        u_if.cw_ready = 1'b0;

`ifdef HAMMING_RX_ERRCNT_EN
        for (int k = 0; k < 300; k++) send_frame(8'hCC, 1'b0);
        idle(2);
        check_eq("errcnt_sat", w_frame_err_cnt, 8'hFF);
        check_eq("ovrcnt_zero", w_overrun_cnt, 8'h00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
